// File: rtl/bin_level_monitor.sv
// bin_level_monitor
//   Averages three raw bin fill readings over windows of 2^AVG_LOG2 ticks and
//   publishes, per bin, the averaged reading, an LED thermometer bar, a 0-9
//   decimal level and a hysteretic full alarm, with a valid/ready handshake.
// Ports
//   Clk, Rst                 clock, async active-high reset
//   tick                     one-cycle sample enable
//   level_raw1..3   [7:0]    raw fill readings
//   SENSOR_bin1..3  [7:0]    averaged reading
//   STATUS_bin1..3  [7:0]    thermometer bar (bit k lit at >= 32k+16)
//   VALUE_bin1..3   [3:0]    decimal level 0-9
//   full_alarm      [2:0]    per-bin full flag (set at 9, clear at <= 7)
//   out_valid / out_ready    result handshake
//   overrun                  sticky: an unaccepted result was overwritten
module bin_level_monitor #(
  parameter int AVG_LOG2 = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       tick,
  input  logic [7:0] level_raw1,
  input  logic [7:0] level_raw2,
  input  logic [7:0] level_raw3,
  output logic [7:0] SENSOR_bin1,
  output logic [7:0] SENSOR_bin2,
  output logic [7:0] SENSOR_bin3,
  output logic [7:0] STATUS_bin1,
  output logic [7:0] STATUS_bin2,
  output logic [7:0] STATUS_bin3,
  output logic [3:0] VALUE_bin1,
  output logic [3:0] VALUE_bin2,
  output logic [3:0] VALUE_bin3,
  output logic [2:0] full_alarm,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun
);
  localparam int ACC_W = 8 + AVG_LOG2;

  typedef enum logic {ACCUM, COMPUTE} state_t;

  state_t                      state_q, state_d;
  logic [2:0][ACC_W-1:0]       acc_q, acc_d, sum_q, sum_d;
  logic [AVG_LOG2-1:0]         cnt_q, cnt_d;
  logic [2:0][7:0]             sensor_q, sensor_d, status_q, status_d;
  logic [2:0][3:0]             value_q, value_d;
  logic [2:0]                  alarm_q, alarm_d;
  logic                        valid_q, valid_d, ovr_q, ovr_d;

  logic [2:0][7:0]             raw, avg, bar;
  logic [2:0][11:0]            prod;
  logic [2:0][3:0]             dec;
  logic                        last_tick;

  assign raw       = {level_raw3, level_raw2, level_raw1};
  assign last_tick = tick && (cnt_q == '1);

  // Result datapath, evaluated from the latched window sums.
  always_comb begin
    for (int b = 0; b < 3; b++) begin
      avg[b]  = sum_q[b][ACC_W-1:AVG_LOG2];
      prod[b] = {4'd0, avg[b]} * 12'd10;
      dec[b]  = prod[b][11:8];
      for (int k = 0; k < 8; k++)
        bar[b][k] = (avg[b] >= 8'(32 * k + 16));
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    sensor_d = sensor_q;
    status_d = status_q;
    value_d  = value_q;
    alarm_d  = alarm_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;

    // Sampling runs in both states so a tick in COMPUTE opens the next window.
    if (tick) begin
      for (int b = 0; b < 3; b++)
        acc_d[b] = acc_q[b] + ACC_W'(raw[b]);
      cnt_d = cnt_q + AVG_LOG2'(1);
      if (last_tick) begin
        sum_d = acc_d;
        acc_d = '0;
        cnt_d = '0;
      end
    end

    case (state_q)
      ACCUM:   if (last_tick) state_d = COMPUTE;
      COMPUTE: state_d = ACCUM;
      default: state_d = ACCUM;
    endcase

    if (state_q == COMPUTE) begin
      sensor_d = avg;
      status_d = bar;
      value_d  = dec;
      for (int b = 0; b < 3; b++) begin
        if (dec[b] == 4'd9)      alarm_d[b] = 1'b1;
        else if (dec[b] <= 4'd7) alarm_d[b] = 1'b0;
      end
      valid_d = 1'b1;
      // A same-edge accept consumes the old result, so only an unaccepted one overruns.
      if (valid_q && !out_ready) ovr_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      sensor_q <= '0;
      status_q <= '0;
      value_q  <= '0;
      alarm_q  <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      sensor_q <= sensor_d;
      status_q <= status_d;
      value_q  <= value_d;
      alarm_q  <= alarm_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign SENSOR_bin1 = sensor_q[0];
  assign SENSOR_bin2 = sensor_q[1];
  assign SENSOR_bin3 = sensor_q[2];
  assign STATUS_bin1 = status_q[0];
  assign STATUS_bin2 = status_q[1];
  assign STATUS_bin3 = status_q[2];
  assign VALUE_bin1  = value_q[0];
  assign VALUE_bin2  = value_q[1];
  assign VALUE_bin3  = value_q[2];
  assign full_alarm  = alarm_q;
  assign out_valid   = valid_q;
  assign overrun     = ovr_q;
endmodule

// File: tb/tb_bin_level_monitor.sv
// Testbench for bin_level_monitor: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a window-level reference model.
module tb_bin_level_monitor;
  localparam int AVG_LOG2 = 2;
  localparam int N = 1 << AVG_LOG2;

  logic       Clk = 1'b0, Rst = 1'b1, tick = 1'b0, out_ready = 1'b0;
  logic [7:0] r1 = '0, r2 = '0, r3 = '0;
  logic [7:0] SENSOR_bin1, SENSOR_bin2, SENSOR_bin3;
  logic [7:0] STATUS_bin1, STATUS_bin2, STATUS_bin3;
  logic [3:0] VALUE_bin1, VALUE_bin2, VALUE_bin3;
  logic [2:0] full_alarm;
  logic       out_valid, overrun;

  bin_level_monitor #(.AVG_LOG2(AVG_LOG2)) dut (
    .Clk(Clk), .Rst(Rst), .tick(tick),
    .level_raw1(r1), .level_raw2(r2), .level_raw3(r3),
    .SENSOR_bin1(SENSOR_bin1), .SENSOR_bin2(SENSOR_bin2), .SENSOR_bin3(SENSOR_bin3),
    .STATUS_bin1(STATUS_bin1), .STATUS_bin2(STATUS_bin2), .STATUS_bin3(STATUS_bin3),
    .VALUE_bin1(VALUE_bin1), .VALUE_bin2(VALUE_bin2), .VALUE_bin3(VALUE_bin3),
    .full_alarm(full_alarm), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun)
  );

  bit clk_en = 1'b1;
  initial forever begin
    #5;
    if (clk_en) Clk = ~Clk;
  end

  typedef struct {
    int         cyc;
    int         ep;
    logic [23:0] sen;
    logic [23:0] sta;
    logic [11:0] val;
    logic [2:0]  alm;
  } exp_t;

  exp_t        q[$];
  logic [23:0] samples[$];
  int          errors = 0, checks = 0;
  int          cyc = 0, pub_due = -1, epoch = 0;
  bit          m_valid = 1'b0, m_ovr = 1'b0, mon_on = 1'b0;
  bit   [2:0]  m_alarm = '0;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endfunction

  // Reference: average of the window, decimal level, bar and hysteresis.
  function automatic exp_t window_result();
    exp_t e;
    e.cyc = cyc + 1;
    e.ep  = epoch;
    e.sen = '0; e.sta = '0; e.val = '0;
    for (int i = 0; i < 3; i++) begin
      int s = 0, a, v;
      foreach (samples[j]) s += int'(samples[j][8*i +: 8]);
      a = s / N;
      v = (a * 10) / 256;
      e.sen[8*i +: 8] = 8'(a);
      e.val[4*i +: 4] = 4'(v);
      for (int k = 0; k < 8; k++) e.sta[8*i + k] = (a >= 32 * k + 16);
      if (v == 9)      m_alarm[i] = 1'b1;
      else if (v <= 7) m_alarm[i] = 1'b0;
    end
    e.alm = m_alarm;
    return e;
  endfunction

  function automatic void model_reset();
    epoch++;
    samples.delete();
    pub_due = -1;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_alarm = '0;
  endfunction

  task automatic step(bit t, int a, int b, int c, bit rdy);
    tick = t; r1 = 8'(a); r2 = 8'(b); r3 = 8'(c); out_ready = rdy;
    @(posedge Clk);
    cyc++;
    if (cyc == pub_due) begin
      if (m_valid && !rdy) m_ovr = 1'b1;
      m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (t) begin
      samples.push_back({8'(c), 8'(b), 8'(a)});
      if (samples.size() == N) begin
        q.push_back(window_result());
        pub_due = cyc + 1;
        samples.delete();
      end
    end
    #1;
    tick = 1'b0;
  endtask

  task automatic window(int a, int b, int c, bit rdy);
    repeat (N) step(1'b1, a, b, c, rdy);
    step(1'b0, 0, 0, 0, rdy);
  endtask

  // Reset with the clock running; tick is held high to show it is ignored.
  task automatic do_reset(int n);
    @(negedge Clk);
    #2;
    Rst = 1'b1;
    model_reset();
    tick = 1'b1; r1 = 8'd255; r2 = 8'd255; r3 = 8'd255;
    repeat (n) begin
      @(posedge Clk);
      cyc++;
    end
    @(negedge Clk);
    #2;
    Rst = 1'b0;
    tick = 1'b0;
  endtask

  // Monitor: handshake flags every cycle; outputs compared against the
  // scoreboard entry on its publish cycle and held between publishes.
  logic [23:0] h_sen = '0, h_sta = '0;
  logic [11:0] h_val = '0;
  logic [2:0]  h_alm = '0;
  int          h_ep = 0;
  always @(negedge Clk) begin
    if (mon_on) begin
      exp_t e;
      if (h_ep != epoch) begin
        h_sen = '0; h_sta = '0; h_val = '0; h_alm = '0;
        h_ep  = epoch;
      end
      while (q.size() > 0 && q[0].ep != epoch) void'(q.pop_front());
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        h_sen = e.sen; h_sta = e.sta; h_val = e.val; h_alm = e.alm;
      end
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("overrun",   {31'd0, overrun},   {31'd0, m_ovr});
      chk("sensor", {8'd0, SENSOR_bin3, SENSOR_bin2, SENSOR_bin1}, {8'd0, h_sen});
      chk("status", {8'd0, STATUS_bin3, STATUS_bin2, STATUS_bin1}, {8'd0, h_sta});
      chk("value",  {20'd0, VALUE_bin3, VALUE_bin2, VALUE_bin1},   {20'd0, h_val});
      chk("alarm",  {29'd0, full_alarm}, {29'd0, h_alm});
    end
  end

  function automatic logic [31:0] all_or();
    return {24'd0, SENSOR_bin1 | SENSOR_bin2 | SENSOR_bin3 | STATUS_bin1 | STATUS_bin2 |
            STATUS_bin3 | {4'd0, VALUE_bin1 | VALUE_bin2 | VALUE_bin3} |
            {5'd0, full_alarm} | {6'd0, out_valid, overrun}};
  endfunction

  initial begin
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    #2;
    Rst = 1'b0;
    chk("reset_outputs", all_or(), 32'd0);
    mon_on = 1'b1;

    // Three bins at 200 / 0 / 255.
    window(200, 0, 255, 1'b0);
    chk("w1_sensor", {8'd0, SENSOR_bin3, SENSOR_bin2, SENSOR_bin1}, 32'h00FF00C8);
    chk("w1_value",  {20'd0, VALUE_bin3, VALUE_bin2, VALUE_bin1},   32'h907);
    chk("w1_status", {8'd0, STATUS_bin3, STATUS_bin2, STATUS_bin1}, 32'h00FF003F);
    chk("w1_alarm",  {29'd0, full_alarm}, 32'd4);
    chk("w1_valid",  {31'd0, out_valid},  32'd1);

    // Reset with the clock stopped clears everything at once.
    @(negedge Clk);
    clk_en = 1'b0;
    #2;
    Rst = 1'b1;
    model_reset();
    #1;
    chk("async_reset", all_or(), 32'd0);
    #4;
    Rst = 1'b0;
    clk_en = 1'b1;

    // Ramp on bin 1.
    step(1'b1, 10, 0, 0, 1'b1);
    step(1'b1, 20, 0, 0, 1'b1);
    step(1'b1, 30, 0, 0, 1'b1);
    step(1'b1, 40, 0, 0, 1'b1);
    step(1'b0, 0, 0, 0, 1'b1);
    chk("ramp_sensor", {24'd0, SENSOR_bin1}, 32'd25);
    chk("ramp_value",  {28'd0, VALUE_bin1},  32'd0);
    chk("ramp_status", {24'd0, STATUS_bin1}, 32'h01);

    // Two windows with no consumer, then one accept.
    window(60, 70, 80, 1'b0);
    window(90, 100, 110, 1'b0);
    chk("ovr_sensor", {24'd0, SENSOR_bin1}, 32'd90);
    chk("ovr_valid",  {31'd0, out_valid}, 32'd1);
    chk("ovr_flag",   {31'd0, overrun},   32'd1);
    step(1'b0, 0, 0, 0, 1'b1);
    chk("acc_valid", {31'd0, out_valid}, 32'd0);
    chk("acc_ovr",   {31'd0, overrun},   32'd1);

    // Hysteresis on bin 3.
    window(0, 0, 255, 1'b1);
    chk("hyst_255", {31'd0, full_alarm[2]}, 32'd1);
    window(0, 0, 210, 1'b1);
    chk("hyst_210_val", {28'd0, VALUE_bin3}, 32'd8);
    chk("hyst_210", {31'd0, full_alarm[2]}, 32'd1);
    window(0, 0, 180, 1'b1);
    chk("hyst_180", {31'd0, full_alarm[2]}, 32'd0);
    step(1'b0, 0, 0, 0, 1'b1);

    // Reset after two ticks discards the partial window.
    step(1'b1, 50, 50, 50, 1'b0);
    step(1'b1, 50, 50, 50, 1'b0);
    do_reset(2);
    repeat (3) step(1'b1, 120, 130, 140, 1'b0);
    step(1'b0, 0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 0, 1'b0);
    chk("partial_novalid", {31'd0, out_valid}, 32'd0);
    step(1'b1, 120, 130, 140, 1'b0);
    step(1'b0, 0, 0, 0, 1'b0);
    chk("fresh_valid",  {31'd0, out_valid}, 32'd1);
    chk("fresh_sensor", {24'd0, SENSOR_bin1}, 32'd120);

    // Tick during COMPUTE becomes sample 1 of the next window.
    repeat (N) step(1'b1, 100, 0, 0, 1'b1);
    repeat (N) step(1'b1, 40, 0, 0, 1'b1);
    step(1'b0, 0, 0, 0, 1'b1);
    chk("compute_tick_sensor", {24'd0, SENSOR_bin1}, 32'd40);
    chk("compute_tick_valid",  {31'd0, out_valid}, 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        int a, b, c;
        a = $urandom_range(0, 1) ? int'($urandom_range(170, 255)) : int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 255));
        c = $urandom_range(0, 1) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 255));
        step(1'(($urandom_range(0, 2) != 0)), a, b, c, 1'(($urandom_range(0, 3) != 0)));
      end
    end
    repeat (3) step(1'b0, 0, 0, 0, 1'b1);
    @(negedge Clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/bin_level_monitor.md
BIN_LEVEL_MONITOR -- requirements
Module: bin_level_monitor

Interface
REQ-001 SHALL have parameter AVG_LOG2, default 2, meaning log2 of the number of samples averaged per window (window = 4 samples).
REQ-002 SHALL have port Clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port Rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port tick, input, 1 bit: sample enable, one Clk cycle wide, from the clock divider.
REQ-005 SHALL have ports level_raw1, level_raw2, level_raw3, input, 8 bits each: raw fill reading for bins 1-3 (0 = empty, 255 = full).
REQ-006 SHALL have ports SENSOR_bin1, SENSOR_bin2, SENSOR_bin3, output, 8 bits each: averaged fill reading.
REQ-007 SHALL have ports STATUS_bin1, STATUS_bin2, STATUS_bin3, output, 8 bits each: thermometer LED bar pattern.
REQ-008 SHALL have ports VALUE_bin1, VALUE_bin2, VALUE_bin3, output, 4 bits each: decimal level 0-9 for the 7-segment display.
REQ-009 SHALL have port full_alarm, output, 3 bits: bit i-1 is the full flag for bin i.
REQ-010 SHALL have port out_valid, output, 1 bit: a published result set is pending.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the pending result.
REQ-012 SHALL have port overrun, output, 1 bit: sticky flag, set when an unaccepted result is overwritten.

Function
REQ-013 SHALL add all three level_raw inputs to per-bin accumulators on every Clk edge with tick=1.
  - Accumulator width: 8+AVG_LOG2 bits; no overflow is possible.
  - A sample counter of AVG_LOG2 bits counts the captured ticks.
REQ-014 On the edge that captures the 2^AVG_LOG2-th tick, SHALL latch the accumulator totals into sum registers, clear the accumulators and counter, and enter COMPUTE.
REQ-015 FSM states SHALL be ACCUM and COMPUTE.
  - COMPUTE lasts exactly one cycle, then returns to ACCUM.
  - A tick arriving during COMPUTE SHALL be captured as sample 1 of the next window.
REQ-016 On the edge leaving COMPUTE, SHALL publish all outputs and set out_valid.
  - Latency is 1 Clk from the final-tick edge to out_valid=1.
REQ-017 SHALL compute SENSOR_binX = sum >> AVG_LOG2 (truncating).
REQ-018 SHALL compute VALUE_binX = (SENSOR_binX*10) >> 8, with a 12-bit intermediate; range 0-9.
REQ-019 SHALL set STATUS_binX bit k (k = 0..7) iff SENSOR_binX >= 32k+16.
REQ-020 full_alarm bit SHALL use hysteresis:
  - set when the published VALUE = 9;
  - cleared when the published VALUE <= 7;
  - otherwise held.
REQ-021 Outputs SHALL hold stable between publishes.
REQ-022 out_valid SHALL clear on the edge where out_valid=1 and out_ready=1, unless a publish occurs on the same edge.
  - On such a same-edge publish, out_valid stays 1 with the new data and overrun is not set.
REQ-023 A publish while out_valid=1 and out_ready=0 SHALL overwrite the outputs, keep out_valid=1, and set overrun.
  - overrun is cleared only by Rst.
REQ-024 tick SHALL be ignored while Rst=1; out_ready is don't-care when out_valid=0.

Reset
REQ-025 Rst=1 SHALL immediately, without waiting for Clk, clear the following to 0:
  - accumulators, sum registers, counter;
  - all SENSOR, STATUS and VALUE outputs;
  - full_alarm, out_valid, overrun;
  - FSM state to ACCUM.
REQ-026 Rst asserted mid-window SHALL discard the partial window; a full 2^AVG_LOG2 fresh ticks are required after release.

Verification
REQ-027 Bench SHALL cover: assert Rst with Clk stopped -> all outputs 0 immediately.
REQ-028 Bench SHALL cover: raw1=200, raw2=0, raw3=255 held for 4 ticks -> 1 cycle after the 4th tick the outputs are:
  - SENSOR = 200/0/255;
  - VALUE = 7/0/9;
  - STATUS = 0x3F/0x00/0xFF;
  - full_alarm = 3'b100, out_valid = 1.
REQ-029 Bench SHALL cover: raw1 sequence 10, 20, 30, 40 -> SENSOR_bin1 = 25, VALUE_bin1 = 0, STATUS_bin1 = 0x01.
REQ-030 Bench SHALL cover: out_ready=0 across two windows -> second result visible, out_valid=1, overrun=1; then out_ready=1 for one cycle -> out_valid=0 next edge, overrun stays 1.
REQ-031 Bench SHALL cover hysteresis on bin3:
  - windows averaging 255, then 210 (VALUE 8) -> full_alarm[2] stays 1;
  - then a window averaging 180 (VALUE 7) -> full_alarm[2] = 0.
REQ-032 Bench SHALL cover: Rst pulse after 2 ticks of a window -> no out_valid until 4 further ticks; also tick in the COMPUTE cycle plus 3 more ticks -> next publish.
